// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the multicycle MIPS datapath, as used by the
// multiply/divide unit:
//   OP_MULT / OP_DIV : encodings of the mult_div 'op' input
//   md_state_t       : mult_div controller states (IDLE, RUN, DONE)
//   MD_ITER          : number of iterations of one multiply or divide
package mips_pkg;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/md_step.sv
// md_step
// One combinational iteration of the multiply/divide unit.
//   op      : OP_MULT selects a radix-2 Booth step, OP_DIV a restoring step
//   accIn   : current 2*WIDTH+1 bit accumulator
//   operand : multiplicand (signed) for MULT, divisor magnitude for DIV
//   accOut  : accumulator after this iteration
// MULT layout: {P_hi, P_lo, q-1}.
// DIV layout:  {remainder (WIDTH+1 bits), quotient/dividend (WIDTH bits)}.
module md_step
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               op,
  input  logic [2*WIDTH:0]   accIn,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH:0]   accOut
);

  logic [WIDTH:0] hiExt;
  logic [WIDTH:0] opExt;
  logic [WIDTH:0] boothSum;
  logic [WIDTH:0] shiftedRem;
  logic [WIDTH:0] trialRem;

  // The Booth add/subtract is done one bit wider than P_hi so that adding or
  // subtracting the most negative multiplicand cannot overflow before the
  // arithmetic shift. The shift itself is just the repositioning of the wide
  // sum on top of P_lo, dropping the old q-1 bit.
  // The restoring step shifts the next dividend bit into the remainder and
  // keeps the trial subtraction only when it did not go negative.
  always_comb begin
    hiExt      = {accIn[2*WIDTH], accIn[2*WIDTH:WIDTH+1]};
    opExt      = {operand[WIDTH-1], operand};
    boothSum   = hiExt;
    shiftedRem = {accIn[2*WIDTH-1:WIDTH], accIn[WIDTH-1]};
    trialRem   = shiftedRem - {1'b0, operand};
    accOut     = accIn;

    if (op == OP_MULT) begin
      case (accIn[1:0])
        2'b01:   boothSum = hiExt + opExt;
        2'b10:   boothSum = hiExt - opExt;
        default: boothSum = hiExt;
      endcase
      accOut = {boothSum, accIn[WIDTH:1]};
    end else begin
      if (!trialRem[WIDTH]) begin
        accOut = {trialRem, accIn[WIDTH-2:0], 1'b1};
      end else begin
        accOut = {shiftedRem, accIn[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mult_div.sv
// mult_div
// Sequential signed MULT/DIV unit writing the architectural HI/LO registers.
//   clock, reset      : system clock, asynchronous active-high reset
//   start, op         : one-cycle request (0 = MULT, 1 = DIV), taken in IDLE
//   src_a, src_b      : multiplicand/dividend and multiplier/divisor
//   busy              : high while an accepted operation is in RUN or DONE
//   done              : one-cycle pulse, HI/LO valid in that cycle
//   div_zero          : pulse with done for a DIV by zero (HI/LO untouched)
//   hi, lo            : HI/LO registers, held between operations
// Every operation takes a fixed 33 cycles; a divide by zero finishes in one.
module mult_div
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    op,
  input  logic signed [WIDTH-1:0] src_a,
  input  logic signed [WIDTH-1:0] src_b,
  output logic                    busy,
  output logic                    done,
  output logic                    div_zero,
  output logic signed [WIDTH-1:0] hi,
  output logic signed [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(MD_ITER);

  md_state_t        state;
  md_state_t        nextState;
  logic [2*WIDTH:0] acc;
  logic [2*WIDTH:0] stepAcc;
  logic [WIDTH-1:0] operand;
  logic [CNT_W-1:0] count;
  logic             opReg;
  logic             negQuot;
  logic             negRem;
  logic             divZeroFlag;
  logic             startDivZero;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic [WIDTH-1:0] resHi;
  logic [WIDTH-1:0] resLo;

  md_step #(.WIDTH(WIDTH)) u_step (
    .op      (opReg),
    .accIn   (acc),
    .operand (operand),
    .accOut  (stepAcc)
  );

  // Operand magnitudes for the restoring divider. The most negative value
  // maps to 2^(WIDTH-1), which still fits the unsigned WIDTH-bit magnitude.
  always_comb begin
    startDivZero = (op == OP_DIV) && (src_b == '0);
    magA = src_a[WIDTH-1] ? WIDTH'(-src_a) : WIDTH'(src_a);
    magB = src_b[WIDTH-1] ? WIDTH'(-src_b) : WIDTH'(src_b);
  end

  // Final HI/LO values, taken from the accumulator as it leaves the last
  // iteration. Division gets its sign fix-up here: the quotient is negated
  // when the operand signs differed, the remainder follows the dividend.
  // The -2^31 / -1 case falls out naturally as quotient 0x80000000.
  always_comb begin
    quotient  = stepAcc[WIDTH-1:0];
    remainder = stepAcc[2*WIDTH-1:WIDTH];
    if (opReg == OP_MULT) begin
      resHi = stepAcc[2*WIDTH:WIDTH+1];
      resLo = stepAcc[WIDTH:1];
    end else begin
      resLo = negQuot ? -quotient  : quotient;
      resHi = negRem  ? -remainder : remainder;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic. A divide by zero skips RUN entirely; a start seen in
  // RUN or DONE is simply not looked at.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (start) begin
          nextState = startDivZero ? DONE : RUN;
        end
      end
      RUN: begin
        if (count == '0) begin
          nextState = DONE;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Status outputs depend only on registered state, so there is no
  // combinational path from the request inputs to them.
  always_comb begin
    busy     = (state != IDLE);
    done     = (state == DONE);
    div_zero = (state == DONE) && divZeroFlag;
  end

  // Datapath registers. Operands are captured only when a start is accepted
  // in IDLE. Each RUN cycle commits one iteration; the last one also writes
  // HI/LO so the result is visible in the DONE cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc         <= '0;
      operand     <= '0;
      count       <= '0;
      opReg       <= 1'b0;
      negQuot     <= 1'b0;
      negRem      <= 1'b0;
      divZeroFlag <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opReg       <= op;
            count       <= CNT_W'(MD_ITER - 1);
            negQuot     <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
            negRem      <= src_a[WIDTH-1];
            divZeroFlag <= startDivZero;
            if (op == OP_MULT) begin
              acc     <= {{WIDTH{1'b0}}, src_b, 1'b0};
              operand <= src_a;
            end else begin
              acc     <= {{(WIDTH+1){1'b0}}, magA};
              operand <= magB;
            end
          end
        end
        RUN: begin
          acc   <= stepAcc;
          count <= count - CNT_W'(1);
          if (count == '0) begin
            hi <= resHi;
            lo <= resLo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// tb_mult_div
// Directed bench for mult_div. A cycle-level reference built from plain
// integer arithmetic predicts busy/done/div_zero/hi/lo every cycle, and
// hand-computed results pin the reference for the listed cases.
module tb_mult_div;
  import mips_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op    = 1'b0;
  logic [31:0] srcA  = '0;
  logic [31:0] srcB  = '0;
  logic        busy;
  logic        done;
  logic        divZero;
  logic [31:0] hi;
  logic [31:0] lo;

  int compared   = 0;
  int mismatched = 0;
  logic checkOn  = 1'b0;

  mult_div #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .src_a    (srcA),
    .src_b    (srcB),
    .busy     (busy),
    .done     (done),
    .div_zero (divZero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: counts down the cycles left in the current operation
  // and holds the architectural HI/LO; results come from 64-bit arithmetic.
  int          remaining = 0;
  logic        pendDz    = 1'b0;
  logic [31:0] pendHi    = '0;
  logic [31:0] pendLo    = '0;
  logic [31:0] expHi     = '0;
  logic [31:0] expLo     = '0;

  always @(posedge clock or posedge reset) begin
    longint a;
    longint b;
    longint p;
    if (reset) begin
      remaining = 0;
      pendDz    = 1'b0;
      expHi     = '0;
      expLo     = '0;
    end else if (remaining == 0) begin
      if (start) begin
        a = longint'($signed(srcA));
        b = longint'($signed(srcB));
        if (op == OP_DIV && b == 0) begin
          remaining = 1;
          pendDz    = 1'b1;
        end else begin
          remaining = 33;
          pendDz    = 1'b0;
          if (op == OP_MULT) begin
            p      = a * b;
            pendHi = p[63:32];
            pendLo = p[31:0];
          end else begin
            p      = a % b;
            pendHi = p[31:0];
            p      = a / b;
            pendLo = p[31:0];
          end
        end
      end
    end else begin
      remaining--;
      if (remaining == 1) begin
        expHi = pendHi;
        expLo = pendLo;
      end
    end
  end

  // Per-cycle comparison against the reference, sampled on the falling edge.
  always @(negedge clock) begin
    if (checkOn) begin
      checkOutput("cyc busy", 64'(busy), 64'(remaining > 0));
      checkOutput("cyc done", 64'(done), 64'(remaining == 1));
      checkOutput("cyc div_zero", 64'(divZero), 64'(remaining == 1 && pendDz));
      checkOutput("cyc hi", 64'(hi), 64'(expHi));
      checkOutput("cyc lo", 64'(lo), 64'(expLo));
    end
  end

  task automatic applyStimulus(input logic opv, input logic [31:0] a, input logic [31:0] b);
    @(posedge clock);
    #1;
    start = 1'b1;
    op    = opv;
    srcA  = a;
    srcB  = b;
    @(posedge clock);
    #1;
    start = 1'b0;
    op    = ~opv;
    srcA  = $urandom;
    srcB  = $urandom;
  endtask

  task automatic waitDone(input string name, input int expLat, output int busyCycles,
                          output logic dzAtDone);
    logic seen;
    seen       = 1'b0;
    busyCycles = 0;
    dzAtDone   = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (busy) busyCycles++;
      if (done) begin
        seen     = 1'b1;
        dzAtDone = divZero;
        checkOutput({name, " latency"}, 64'(k), 64'(expLat));
        break;
      end
    end
    if (!seen) checkOutput({name, " timeout"}, 64'(0), 64'(1));
  endtask

  task automatic runOp(input string name, input logic opv, input logic [31:0] a,
                       input logic [31:0] b, input int expLat, input logic expDz,
                       input logic [31:0] wantHi, input logic [31:0] wantLo);
    int   busyCycles;
    logic dz;
    applyStimulus(opv, a, b);
    waitDone(name, expLat, busyCycles, dz);
    checkOutput({name, " busy cycles"}, 64'(busyCycles), 64'(expLat));
    checkOutput({name, " div_zero"}, 64'(dz), 64'(expDz));
    checkOutput({name, " hi"}, 64'(hi), 64'(wantHi));
    checkOutput({name, " lo"}, 64'(lo), 64'(wantLo));
  endtask

  initial begin
    int   busyCycles;
    int   doneCount;
    logic dz;

    #1 reset = 1'b1;
    #21 reset = 1'b0;
    checkOn = 1'b1;
    @(negedge clock);
    checkOutput("reset busy", 64'(busy), 64'(0));
    checkOutput("reset done", 64'(done), 64'(0));
    checkOutput("reset hi", 64'(hi), 64'(0));
    checkOutput("reset lo", 64'(lo), 64'(0));

    runOp("mult 7*-3", OP_MULT, 32'd7, -32'sd3, 33, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB);
    runOp("mult min*min", OP_MULT, 32'h80000000, 32'h80000000, 33, 1'b0, 32'h40000000, 32'h0);
    runOp("div -7/2", OP_DIV, -32'sd7, 32'd2, 33, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("div min/-1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 33, 1'b0, 32'h0, 32'h80000000);
    runOp("div 1105/32", OP_DIV, 32'd1105, 32'd32, 33, 1'b0, 32'h11, 32'h22);
    runOp("div 5/0", OP_DIV, 32'd5, 32'd0, 1, 1'b1, 32'h11, 32'h22);
    @(negedge clock);
    checkOutput("div0 after busy", 64'(busy), 64'(0));
    checkOutput("div0 after div_zero", 64'(divZero), 64'(0));

    // Extra starts during RUN (a would-be divide by zero) and during DONE.
    applyStimulus(OP_MULT, 32'd12345, -32'sd678);
    busyCycles = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (k == 5) begin
        start = 1'b1; op = OP_DIV; srcA = 32'd99; srcB = 32'd0;
      end else if (k == 6) begin
        start = 1'b0;
      end
      if (done) begin
        busyCycles = k;
        start = 1'b1; op = OP_MULT; srcA = 32'd3; srcB = 32'd3;
        break;
      end
    end
    checkOutput("extra latency", 64'(busyCycles), 64'(33));
    checkOutput("extra hi", 64'(hi), 64'(32'hFFFFFFFF));
    checkOutput("extra lo", 64'(lo), 64'(32'hFF80490A));
    @(negedge clock);
    start = 1'b0;
    checkOutput("extra start in done ignored", 64'(busy), 64'(0));
    runOp("div 100/-7", OP_DIV, 32'd100, -32'sd7, 33, 1'b0, 32'h2, 32'hFFFFFFF2);

    // Asynchronous reset in the middle of a multiply.
    applyStimulus(OP_MULT, 32'd7, -32'sd3);
    for (int k = 1; k < 10; k++) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("async reset busy", 64'(busy), 64'(0));
    checkOutput("async reset done", 64'(done), 64'(0));
    checkOutput("async reset hi", 64'(hi), 64'(0));
    checkOutput("async reset lo", 64'(lo), 64'(0));
    @(negedge clock);
    #2 reset = 1'b0;
    doneCount = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (done || busy) doneCount++;
    end
    checkOutput("no done after reset", 64'(doneCount), 64'(0));

    runOp("mult after reset", OP_MULT, -32'sd2, -32'sd5, 33, 1'b0, 32'h0, 32'hA);

    @(negedge clock);
    checkOn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mult_div.md
# mult_div

Sequential signed multiply/divide unit for the multicycle MIPS datapath. It implements MULT and DIV. It sits beside the shift unit in the execute stage, reads the same A/B operand registers, and writes the architectural HI/LO registers that MFHI/MFLO later route to the write-back mux. The control unit starts an operation with a one-cycle pulse and stalls on `busy` until `done`.

## Interface
- `WIDTH`, 32: operand width. HI and LO are each `WIDTH` bits.
- `clock`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  one-cycle request to begin an operation. Sampled only in IDLE.
- `op`  input  1  operation select: 0 = MULT, 1 = DIV. Sampled with `start`.
- `src_a`  input  signed 32  multiplicand or dividend. Sampled with `start`.
- `src_b`  input  signed 32  multiplier or divisor. Sampled with `start`.
- `busy`  output  1  high from the cycle after an accepted `start` through the DONE cycle.
- `done`  output  1  one-cycle pulse. HI/LO are valid in that same cycle.
- `div_zero`  output  1  one-cycle pulse coincident with `done` when a DIV had `src_b == 0`.
- `hi`  output  signed 32  HI register; holds its value between operations.
- `lo`  output  signed 32  LO register; holds its value between operations.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - On `start`, latch the operands into internal registers, load the iteration counter with 31, and go to RUN.
  - Exception: DIV with `src_b == 0` goes directly to DONE with `div_zero` set.
- RUN:
  - Performs one iteration per cycle.
  - The counter decrements each cycle. At count 0, go to DONE.
- DONE:
  - Assert `done`.
  - Write `hi`/`lo`, except in the divide-by-zero case, where HI/LO are left unchanged.
  - Return to IDLE.
- MULT:
  - Radix-2 Booth algorithm over a 65-bit accumulator {P_hi, P_lo, q-1}.
  - Arithmetic right shift by one per iteration.
  - Result: {hi, lo} = full 64-bit signed product.
- DIV:
  - Restoring division on operand magnitudes, one quotient bit per iteration.
  - Sign fix-up is applied when entering DONE:
    - Quotient is negative iff the operand signs differ (truncation toward zero).
    - Remainder takes the sign of the dividend.
  - LO = quotient, HI = remainder.
- Overflow case: −2^31 / −1 gives LO = 0x80000000, HI = 0. No flag is raised.
- `start` while not in IDLE is ignored and has no side effects.
- `op` and `src_*` are don't-care outside the sampling cycle.
- Reset, asynchronous and allowed at any time including mid-RUN:
  - state = IDLE
  - `hi` = `lo` = 0
  - `busy` = `done` = `div_zero` = 0
  - counter and internal registers = 0
- Any operation in progress is discarded on reset.

## Timing
- `start` sampled at edge N.
- Normal MULT/DIV:
  - `busy` high from cycle N+1 through N+33.
  - `done` and new `hi`/`lo` visible in cycle N+33; RUN occupies cycles N+1..N+32.
  - Fixed latency of 33 cycles, independent of operand values.
- Divide by zero:
  - `busy`, `done` and `div_zero` all high in cycle N+1 only.
- Back-to-back operation:
  - The earliest accepted next `start` is in the cycle after DONE, when the FSM is back in IDLE.
  - A `start` held high during DONE is not accepted.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- The shared package `mips_pkg` holds:
  - the `op` encodings `OP_MULT` and `OP_DIV`
  - the `md_state_t` enum (IDLE, RUN, DONE)
  - the iteration count constant `MD_ITER = 32`
- The iteration datapath may be split into one sub-module, `md_step`. It is combinational and computes the next accumulator for either the Booth step or the restoring step. The FSM, counter and HI/LO registers stay in `mult_div`.

## Test plan
- MULT 7 × −3: `done` at N+33, `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB, `busy` high for exactly 33 cycles.
- MULT 0x80000000 × 0x80000000: `hi` = 0x40000000, `lo` = 0x00000000.
- DIV −7 / 2: `lo` = 0xFFFFFFFD (−3), `hi` = 0xFFFFFFFF (−1). DIV 0x80000000 / 0xFFFFFFFF: `lo` = 0x80000000, `hi` = 0.
- DIV 5 / 0 with prior `hi`/`lo` = 0x11/0x22:
  - `done` and `div_zero` high in cycle N+1 only.
  - `hi`/`lo` remain 0x11/0x22.
- Extra `start` pulses during RUN and DONE:
  - They are ignored.
  - The result matches the first operation.
  - The next `start`, issued in IDLE, produces its own correct result.
- Assert `reset` at cycle N+10 of a MULT:
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - After release, no `done` appears until a new `start`.
